// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and default width for the restoring shift divider.
`default_nettype none

package div_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width needed to hold an iteration count of n (0..n inclusive).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_iter_counter.sv
// div_iter_counter: loadable iteration down-counter; last flags the step that brings it to zero.
`default_nettype none

module div_iter_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

`default_nettype wire

// File: rtl/shift_divider.sv
// shift_divider: 2N/N unsigned restoring divider, one quotient bit per cycle.
// Optional divide-by-zero flag port dz is built when DIV_ZERO_FLAG_EN is defined.
`default_nettype none

module shift_divider
  import div_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           ovf
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic           dz
`endif
);

  localparam int CW = cnt_width(N);

  state_t state, state_next;

  logic         load, check, step, finish, last;
  logic [N-1:0] a, q, b;
  logic         ovf_pend;
  logic         a_ge_b;
  logic [N:0]   partial;
  logic         fits;
  logic [N-1:0] trial;

  assign a_ge_b  = (a >= b);
  assign partial = {a, q[N-1]};
  assign fits    = (partial >= {1'b0, b});
  // a < b holds throughout, so the difference always fits in N bits when it is kept.
  assign trial   = partial[N-1:0] - b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start)  state_next = ST_CHECK;
      ST_CHECK: state_next = a_ge_b ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (last)   state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    load   = 1'b0;
    check  = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      ST_IDLE:  load = start;
      ST_CHECK: begin busy = 1'b1; check = 1'b1; end
      ST_SHIFT: begin busy = 1'b1; step = 1'b1; end
      ST_DONE:  begin busy = 1'b1; finish = 1'b1; end
      default:  busy = 1'b0;
    endcase
  end

  div_iter_counter #(
    .W(CW)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (CW'(N)),
    .dec      (step),
    .last     (last)
  );

`ifdef DIV_ZERO_FLAG_EN
  logic dz_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_pend <= 1'b0;
      dz      <= 1'b0;
    end else if (load) begin
      dz_pend <= 1'b0;
      dz      <= 1'b0;
    end else begin
      if (check)  dz_pend <= (b == '0);
      if (finish) dz      <= dz_pend;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      q         <= '0;
      b         <= '0;
      ovf_pend  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a        <= dividend[2*N-1:N];
        q        <= dividend[N-1:0];
        b        <= divisor;
        ovf_pend <= 1'b0;
        ovf      <= 1'b0;
      end
      if (check) begin
        ovf_pend <= a_ge_b;
      end
      if (step) begin
        a <= fits ? trial : partial[N-1:0];
        q <= {q[N-2:0], fits};
      end
      if (finish) begin
        done      <= 1'b1;
        ovf       <= ovf_pend;
        quotient  <= ovf_pend ? '1 : q;
        remainder <= ovf_pend ? '0 : a;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_divider.sv
// tb_shift_divider: vector table, random model comparison and multi-cycle corner sequences.
`default_nettype none

module tb_shift_divider;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic [N-1:0]   quotient, remainder;
  logic           busy, done, ovf;
`ifdef DIV_ZERO_FLAG_EN
  logic           dz;
`endif

  int tests = 0;
  int fails = 0;

  shift_divider #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .dz        (dz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        o;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer division with an out-of-range test on the quotient.
  task automatic model(input logic [15:0] dd, input logic [7:0] dv,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic o, output int lat);
    int unsigned qq;
    if (dv == 0) begin
      o = 1'b1;
    end else begin
      qq = 32'(dd) / 32'(dv);
      o  = (qq > 255);
    end
    if (o) begin
      q = 8'hFF; r = 8'h00; lat = 2;
    end else begin
      q = 8'(32'(dd) / 32'(dv));
      r = 8'(32'(dd) % 32'(dv));
      lat = N + 2;
    end
  endtask

  // Caller is positioned at a negedge; start is sampled at the next posedge.
  task automatic run_div(input logic [15:0] dd, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic o, output logic z,
                         output int lat, output int npulse);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ovf_cleared_on_start", ovf, 0);
    lat = -1; npulse = 0; q = '0; r = '0; o = 1'b0; z = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (lat < 0) begin
          lat = c; q = quotient; r = remainder; o = ovf;
`ifdef DIV_ZERO_FLAG_EN
          z = dz;
`endif
        end
      end
    end
  endtask

  initial begin
    logic [7:0] q, r, eq, er;
    logic o, z, eo;
    int lat, np, elat;
    logic [15:0] rdd;
    logic [7:0] rdv;

    vecs[0] = '{16'd100,  8'd7,   8'd14,  8'd2,   1'b0, 10};
    vecs[1] = '{16'h7FFF, 8'hFF,  8'h80,  8'h7F,  1'b0, 10};
    vecs[2] = '{16'h0500, 8'h05,  8'hFF,  8'h00,  1'b1, 2};
    vecs[3] = '{16'h1234, 8'h00,  8'hFF,  8'h00,  1'b1, 2};
    vecs[4] = '{16'd200,  8'd9,   8'd22,  8'd2,   1'b0, 10};
    vecs[5] = '{16'd0,    8'd5,   8'd0,   8'd0,   1'b0, 10};
    vecs[6] = '{16'h04FF, 8'h05,  8'hFF,  8'h04,  1'b0, 10};
    vecs[7] = '{16'hFFFF, 8'hFF,  8'hFF,  8'h00,  1'b1, 2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start on the first edge after reset release
    run_div(16'd100, 8'd7, q, r, o, z, lat, np);
    check("first_after_reset_q", q, 14);
    check("first_after_reset_lat", lat, 10);

    foreach (vecs[i]) begin
      @(negedge clk);
      run_div(vecs[i].dd, vecs[i].dv, q, r, o, z, lat, np);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
      check($sformatf("vec%0d_ovf", i), o, vecs[i].o);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_pulses", i), np, 1);
`ifdef DIV_ZERO_FLAG_EN
      check($sformatf("vec%0d_dz", i), z, (vecs[i].dv == 0));
`endif
      check($sformatf("vec%0d_hold_q", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_hold_ovf", i), ovf, vecs[i].o);
    end

    // Randomised operands against the reference model
    for (int i = 0; i < 40; i++) begin
      rdv = 8'($urandom_range(0, 255));
      if ((i % 2 == 0) && (rdv != 0))
        rdd = 16'($urandom_range(0, 32'(rdv) * 256 - 1));
      else
        rdd = 16'($urandom_range(0, 65535));
      model(rdd, rdv, eq, er, eo, elat);
      @(negedge clk);
      run_div(rdd, rdv, q, r, o, z, lat, np);
      check($sformatf("rnd%0d_q %0h/%0h", i, rdd, rdv), q, eq);
      check($sformatf("rnd%0d_r %0h/%0h", i, rdd, rdv), r, er);
      check($sformatf("rnd%0d_ovf", i), o, eo);
      check($sformatf("rnd%0d_lat", i), lat, elat);
`ifdef DIV_ZERO_FLAG_EN
      check($sformatf("rnd%0d_dz", i), z, (rdv == 0));
`endif
    end

    // Start pulsed again during SHIFT must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; np = 0; q = '0; r = '0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (c == 4) begin start = 1'b1; dividend = 16'd50; divisor = 8'd3; end
      if (c == 6) start = 1'b0;
      if (done) begin
        np++;
        if (lat < 0) begin lat = c; q = quotient; r = remainder; end
      end
    end
    check("restart_q", q, 14);
    check("restart_r", r, 2);
    check("restart_lat", lat, 10);
    check("restart_pulses", np, 1);

    // Asynchronous reset during SHIFT, then a fresh division
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div(16'd200, 8'd9, q, r, o, z, lat, np);
    check("postrst_q", q, 22);
    check("postrst_r", r, 2);
    check("postrst_ovf", o, 0);
    check("postrst_lat", lat, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_divider.md
SHIFT_DIVIDER -- requirements
Module: shift_divider

Interface
REQ-001 SHALL have parameter N, default 8: divisor, quotient and remainder width; dividend width is 2N.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, 2N: unsigned dividend, captured on accepted start.
REQ-006 SHALL have port divisor, input, N: unsigned divisor, captured on accepted start.
REQ-007 SHALL have port quotient, output, N: registered result.
REQ-008 SHALL have port remainder, output, N: registered result.
REQ-009 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1: single-cycle pulse; results valid from this cycle on.
REQ-011 SHALL have port ovf, output, 1: quotient does not fit in N bits; valid with done.
REQ-012 SHALL have port dz, output, 1, present only under DIV_ZERO_FLAG_EN: divisor was zero.

Function
REQ-013 SHALL implement FSM states IDLE, CHECK, SHIFT, DONE.
- IDLE -> CHECK on start=1.
- CHECK -> DONE on overflow, else -> SHIFT.
- SHIFT -> DONE when the iteration counter reaches zero.
- DONE -> IDLE unconditionally.
REQ-014 SHALL, on accepted start, load A = dividend[2N-1:N], Q = dividend[N-1:0], B = divisor, and the iteration counter = N.
REQ-015 SHALL detect overflow in CHECK when A >= B; this includes B = 0.
REQ-016 SHALL, on overflow, set quotient = all ones, remainder = 0 and ovf = 1, and skip SHIFT.
REQ-017 SHALL, in each SHIFT cycle, perform one restoring step:
- shift {A,Q} left one bit into an (N+1)-bit partial remainder;
- compute trial = partial - {0,B};
- if trial >= 0: A = trial[N-1:0] and Q[0] = 1;
- else: A = partial[N-1:0] and Q[0] = 0;
- decrement the counter.
REQ-018 SHALL produce final quotient = Q and remainder = A, registered on entry to DONE.
REQ-019 SHALL assert done exactly N+2 cycles after the start-sampling edge on the normal path, and 2 cycles after it on overflow.
REQ-020 SHALL ignore start while busy; a start held high during DONE is not accepted until IDLE.
REQ-021 SHALL hold quotient, remainder, ovf and dz stable until the next accepted start.
REQ-022 SHALL clear ovf and dz at the next accepted start.

Reset
REQ-023 SHALL, when rst_n=0 (asynchronously, including mid-operation), force state = IDLE and zero quotient, remainder, busy, done, ovf, dz, A, Q, B and the counter.
REQ-024 SHALL accept a start on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with DIV_ZERO_FLAG_EN defined, provide port dz, asserted with done when B = 0; ovf is also asserted in that case.
REQ-026 SHALL, without DIV_ZERO_FLAG_EN, omit port dz; division by zero is reported only through ovf.

Structure
REQ-027 SHALL place the FSM state encoding typedef and the default N constant in shared package div_pkg.
REQ-028 SHALL place the loadable down-counter with zero detect in sub-module div_iter_counter, instantiated once.

Verification
REQ-029 SHALL cover: dividend 16'd100, divisor 8'd7 -> quotient 14, remainder 2, ovf 0, done on cycle 10 after start.
REQ-030 SHALL cover: dividend 16'h7FFF, divisor 8'hFF -> quotient 8'h80, remainder 8'h7F, ovf 0.
REQ-031 SHALL cover: dividend 16'h0500, divisor 8'h05 -> ovf 1, quotient 8'hFF, remainder 0, done on cycle 2.
REQ-032 SHALL cover: divisor 8'h00 with any dividend -> ovf 1, plus dz 1 when DIV_ZERO_FLAG_EN is defined.
REQ-033 SHALL cover: start pulsed again during SHIFT of 100/7 -> ignored; the result is still 14 r 2 with one done pulse.
REQ-034 SHALL cover: rst_n low during SHIFT -> all outputs 0 immediately; a new start for 200/9 -> quotient 22, remainder 2.
